// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-side bus responder: state encodings,
// bus direction codes, widths and the latched transaction payload.
package mem_bus_responder_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   // Bus direction as seen from the CPU
   localparam logic CTRL_READ  = 1'b1;
   localparam logic CTRL_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_TURN = 2'd3
   } state_e;

   // Everything captured at request accept; later bus activity is ignored
   typedef struct packed {
      logic              rd;
      logic              mis;
      logic [DATA_W-1:0] wdata;
   } txn_t;

endpackage

// File: rtl/mem_bus_responder_ram_sp.sv
// Single-port synchronous RAM, read-before-write, no reset.
// Ports: clk, we (write enable), idx (word index), wdata, rdata (registered read).
module ram_sp #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10,
   parameter int unsigned W     = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Storage array and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the shared bidirectional CPU data bus.
// Accepts a request, waits WAIT_STATES cycles, answers with a one-cycle
// ready pulse, then spends one turnaround cycle with the bus released.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   data         shared 32-bit bus; driven only in the response cycle of a read
//   addr         byte address (word index = addr[AW+1:2])
//   req          request strobe, held by the CPU until ready
//   ctrl         1 = CPU read, 0 = CPU write
//   ready        one-cycle response pulse
//   err          misaligned-address flag, pulses with ready
//   busy         high whenever the responder is not idle
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   inout  wire  [DATA_W-1:0] data,
   input  logic [31:0]       addr,
   input  logic              req,
   input  logic              ctrl,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]     idx_q, idx_d;
   txn_t              txn_q, txn_d;
   logic              oe;
   logic              ready_d, err_d, busy_d, oe_d;
   logic              ram_we;
   logic [DATA_W-1:0] rdata;
   logic              unused_addr;

   // Address bits above the RAM index only alias; they are deliberately dropped
   assign unused_addr = ^addr[31:AW+2];

   // Next-state, latch and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      txn_d   = txn_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               idx_d     = addr[AW+1:2];
               txn_d.rd  = (ctrl == CTRL_READ);
               txn_d.mis = |addr[1:0];
               if (ctrl == CTRL_WRITE) begin
                  txn_d.wdata = data;
               end
               cnt_d   = CNT_LOAD;
               state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_TURN;
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_RESP);
      err_d   = ready_d & txn_d.mis;
      oe_d    = ready_d & txn_d.rd;
      busy_d  = (state_d != ST_IDLE);
   end

   // State, latches and registered outputs; reset releases the bus at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         txn_q   <= '0;
         ready   <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         oe      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         txn_q   <= txn_d;
         ready   <= ready_d;
         err     <= err_d;
         busy    <= busy_d;
         oe      <= oe_d;
      end
   end

   // Commit an aligned write on the edge that closes the response cycle
   assign ram_we = (state_q == ST_RESP) & ~txn_q.rd & ~txn_q.mis;

   // idx_d follows addr on accept so a zero-wait read is issued on that edge
   ram_sp #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .idx   (idx_d),
      .wdata (txn_q.wdata),
      .rdata (rdata)
   );

   // Misaligned reads return zero instead of RAM contents
   assign data = oe ? (txn_q.mis ? '0 : rdata) : 'z;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0
// instance, directed scenarios plus random traffic against a word-array model.
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a, req_b;
   logic [31:0] addr;
   logic        ctrl;
   logic        drv_a, drv_b;
   logic [31:0] drv_val;
   wire  [31:0] data_a, data_b;
   logic        ready_a, err_a, busy_a;
   logic        ready_b, err_b, busy_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [1024];
   bit          known [1024];

   always #5 clk = ~clk;

   assign data_a = drv_a ? drv_val : 'z;
   assign data_b = drv_b ? drv_val : 'z;

   mem_bus_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_a (
      .clk(clk), .rst_n(rst_n), .data(data_a), .addr(addr), .req(req_a),
      .ctrl(ctrl), .ready(ready_a), .err(err_a), .busy(busy_a));

   mem_bus_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_b (
      .clk(clk), .rst_n(rst_n), .data(data_b), .addr(addr), .req(req_b),
      .ctrl(ctrl), .ready(ready_b), .err(err_b), .busy(busy_b));

   function automatic logic [31:0] bus_of(input bit b);
      return b ? data_b : data_a;
   endfunction
   function automatic logic rdy_of(input bit b);
      return b ? ready_b : ready_a;
   endfunction
   function automatic logic err_of(input bit b);
      return b ? err_b : err_a;
   endfunction
   function automatic logic busy_of(input bit b);
      return b ? busy_b : busy_a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus must be released: a random pattern driven by the bench must read back intact
   task automatic probe(input bit b, input string tag);
      drv_val = $urandom;
      if (b) drv_b = 1'b1; else drv_a = 1'b1;
      #1;
      chk({tag, "_released"}, bus_of(b), drv_val);
      drv_a = 1'b0;
      drv_b = 1'b0;
   endtask

   // One transaction, called and returning at a negedge in the idle cycle
   task automatic txn(input bit b, input bit rd, input logic [31:0] a,
                      input logic [31:0] wd, input bit hold, input string tag);
      int          ws  = b ? 0 : 2;
      int          cyc = 0;
      bit          mis = |a[1:0];
      int unsigned i   = int'(a[11:2]);
      addr = a;
      ctrl = rd;
      if (b) req_b = 1'b1; else req_a = 1'b1;
      if (!rd) begin
         drv_val = wd;
         if (b) drv_b = 1'b1; else drv_a = 1'b1;
      end
      @(posedge clk);
      #1;
      drv_a = 1'b0;
      drv_b = 1'b0;
      addr  = $urandom;          // post-accept changes must be ignored
      ctrl  = 1'($urandom);
      @(negedge clk);
      cyc = 1;
      while (!rdy_of(b) && cyc < 20) begin
         chk({tag, "_wait_busy"}, 32'(busy_of(b)), 32'd1);
         probe(b, {tag, "_wait"});
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(ws + 1));
      chk({tag, "_err"}, 32'(err_of(b)), 32'(mis));
      chk({tag, "_resp_busy"}, 32'(busy_of(b)), 32'd1);
      if (rd) begin
         if (mis) chk({tag, "_rdata"}, bus_of(b), 32'h0);
         else if (known[i]) chk({tag, "_rdata"}, bus_of(b), mem_m[i]);
      end else begin
         probe(b, {tag, "_wresp"});
         if (!mis) begin
            mem_m[i] = wd;
            known[i] = 1'b1;
         end
      end
      if (!hold) begin
         req_a = 1'b0;
         req_b = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_turn_ready"}, 32'(rdy_of(b)), 32'd0);
      chk({tag, "_turn_busy"}, 32'(busy_of(b)), 32'd1);
      probe(b, {tag, "_turn"});
      @(negedge clk);
      chk({tag, "_idle_busy"}, 32'(busy_of(b)), 32'd0);
      chk({tag, "_idle_ready"}, 32'(rdy_of(b)), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      addr  = '0;
      ctrl  = 1'b0;
      drv_a = 1'b0;
      drv_b = 1'b0;
      drv_val = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready_a", 32'(ready_a), 32'd0);
      chk("rst_err_a", 32'(err_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      probe(1'b0, "rst_a");
      probe(1'b1, "rst_b");
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read back
      txn(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "t1w");
      txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, "t1r");
      chk("t1_model", mem_m[4], 32'hDEADBEEF);

      // Back-to-back reads with req held high across the turnaround
      txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, "t2a");
      txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, "t2b");

      // Misaligned write leaves word 4 alone; misaligned read returns zero
      txn(1'b0, 1'b0, 32'h10, 32'h11112222, 1'b0, "t3pre");
      txn(1'b0, 1'b0, 32'h13, 32'h00001234, 1'b0, "t3w");
      txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, "t3r");
      txn(1'b0, 1'b1, 32'h13, 32'h0, 1'b0, "t3mr");

      // Zero wait states
      txn(1'b1, 1'b0, 32'h44, 32'h0BADCAFE, 1'b0, "t4w");
      txn(1'b1, 1'b1, 32'h44, 32'h0, 1'b0, "t4r");

      // Reset mid-wait of a write abandons it
      txn(1'b0, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, "t5pre");
      addr = 32'h20;
      ctrl = 1'b0;
      req_a = 1'b1;
      drv_val = 32'h0BAD0BAD;
      drv_a = 1'b1;
      @(posedge clk);
      #1;
      drv_a = 1'b0;
      @(negedge clk);
      chk("t5_busy_before", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_ready", 32'(ready_a), 32'd0);
      chk("t5_busy", 32'(busy_a), 32'd0);
      chk("t5_err", 32'(err_a), 32'd0);
      probe(1'b0, "t5");
      req_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, "t5r");

      // Address alias above the RAM index
      txn(1'b0, 1'b0, 32'h1000, 32'hA5A5A5A5, 1'b0, "t6w");
      txn(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, "t6r");
      chk("t6_model", mem_m[0], 32'hA5A5A5A5);

      // Random traffic on the wait-state instance, optional back-to-back
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a = $urandom;
         a[11:2] = 10'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         txn(1'b0, 1'($urandom), a, $urandom, (n != 39) && 1'($urandom), "rnd_a");
      end
      req_a = 1'b0;

      // Random traffic on the zero-wait instance (separate RAM)
      for (int k = 0; k < 1024; k++) known[k] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         logic [31:0] a = $urandom;
         a[11:2] = 10'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         txn(1'b1, 1'($urandom), a, $urandom, 1'b0, "rnd_b");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
